// File: rtl/maxnet_controller.sv
`default_nettype none
// ============================================================================
// Module      : maxnet_controller
// Description : Control FSM for the four-neuron winner-take-all datapath.
//               Steps the datapath through load, iterate (calc/update),
//               convergence check and result capture, bounds the number of
//               iterations and reports done/timeout to the host.
// Ports       : clk, rst        - clock, asynchronous active-high reset
//               start           - host run request (level, sampled in IDLE)
//               complete        - datapath convergence flag
//               sel             - 1 = datapath uses initial X values
//               en0..en3        - X load, PU regs, A regs, result reg enables
//               ready           - controller idle
//               done            - one-cycle end-of-run pulse
//               timeout         - last run ended without convergence
//               iters           - iterations executed in current/last run
// Revision    : 1.0 - initial release
// ============================================================================
module maxnet_controller #(
    parameter int MAX_ITER = 15,
    parameter int ITER_W   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              complete,
    output logic              sel,
    output logic              en0,
    output logic              en1,
    output logic              en2,
    output logic              en3,
    output logic              ready,
    output logic              done,
    output logic              timeout,
    output logic [ITER_W-1:0] iters
);

    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_LOAD   = 3'd1;
    localparam logic [2:0] c_ST_CALC   = 3'd2;
    localparam logic [2:0] c_ST_UPDATE = 3'd3;
    localparam logic [2:0] c_ST_CHECK  = 3'd4;
    localparam logic [2:0] c_ST_WRITE  = 3'd5;
    localparam logic [2:0] c_ST_FIN    = 3'd6;

    localparam logic [ITER_W-1:0] c_MAX_ITER = ITER_W'(MAX_ITER);

    logic [2:0]        r_state;
    logic [2:0]        w_state_nxt;
    logic [ITER_W-1:0] r_iters;
    logic              r_timeout;
    logic              w_accept;

    assign w_accept = (r_state == c_ST_IDLE) && start;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Iteration counter and timeout flag. The counter can never pass
    // MAX_ITER because CHECK leaves the loop once it reaches that value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_iters   <= '0;
            r_timeout <= 1'b0;
        end else begin
            if (w_accept) begin
                r_iters   <= '0;
                r_timeout <= 1'b0;
            end else if (r_state == c_ST_UPDATE) begin
                r_iters <= r_iters + ITER_W'(1);
            end else if ((r_state == c_ST_CHECK) && !complete &&
                         (r_iters == c_MAX_ITER)) begin
                r_timeout <= 1'b1;
            end
        end
    end

    // Next-state and Moore output decode. Outputs depend only on the state
    // register and r_iters; complete/start only steer the next state.
    always_comb begin
        w_state_nxt = r_state;
        sel         = 1'b0;
        en0         = 1'b0;
        en1         = 1'b0;
        en2         = 1'b0;
        en3         = 1'b0;
        ready       = 1'b0;
        done        = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                ready = 1'b1;
                if (start) begin
                    w_state_nxt = c_ST_LOAD;
                end
            end
            c_ST_LOAD: begin
                en0         = 1'b1;
                w_state_nxt = c_ST_CALC;
            end
            c_ST_CALC: begin
                en1 = 1'b1;
                // First pass consumes the freshly loaded X values.
                sel         = (r_iters == '0);
                w_state_nxt = c_ST_UPDATE;
            end
            c_ST_UPDATE: begin
                en2         = 1'b1;
                w_state_nxt = c_ST_CHECK;
            end
            c_ST_CHECK: begin
                if (complete) begin
                    w_state_nxt = c_ST_WRITE;
                end else if (r_iters == c_MAX_ITER) begin
                    // Timeout skips WRITE so the result register is untouched.
                    w_state_nxt = c_ST_FIN;
                end else begin
                    w_state_nxt = c_ST_CALC;
                end
            end
            c_ST_WRITE: begin
                en3         = 1'b1;
                w_state_nxt = c_ST_FIN;
            end
            c_ST_FIN: begin
                done        = 1'b1;
                w_state_nxt = c_ST_IDLE;
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    assign timeout = r_timeout;
    assign iters   = r_iters;

endmodule
`default_nettype wire

// File: tb/tb_maxnet_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_maxnet_controller
// Description : Self-checking bench for maxnet_controller. A reference model
//               pushes the expected per-cycle output vector of each run into a
//               scoreboard queue; each scenario task pops and compares one
//               entry per cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_maxnet_controller;

    localparam int MAX_ITER = 15;
    localparam int ITER_W   = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              start = 1'b0;
    logic              complete = 1'b0;
    logic              sel, en0, en1, en2, en3, ready, done, timeout;
    logic [ITER_W-1:0] iters;

    always #5 clk = ~clk;

    maxnet_controller #(
        .MAX_ITER(MAX_ITER),
        .ITER_W  (ITER_W)
    ) u_dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .complete(complete),
        .sel     (sel),
        .en0     (en0),
        .en1     (en1),
        .en2     (en2),
        .en3     (en3),
        .ready   (ready),
        .done    (done),
        .timeout (timeout),
        .iters   (iters)
    );

    typedef struct packed {
        logic              ready;
        logic              sel;
        logic              en0;
        logic              en1;
        logic              en2;
        logic              en3;
        logic              done;
        logic              timeout;
        logic [ITER_W-1:0] iters;
    } obs_t;

    obs_t exp_q[$];
    int   passed      = 0;
    int   total       = 0;
    int   onehot_viol = 0;

    always @(negedge clk) begin
        if ($countones({en0, en1, en2, en3}) > 1) onehot_viol++;
    end

    function automatic obs_t sample();
        sample = {ready, sel, en0, en1, en2, en3, done, timeout, iters};
    endfunction

    function automatic obs_t mk(logic r, logic s, logic [3:0] en, logic d,
                                logic t, int it);
        obs_t o;
        o.ready   = r;
        o.sel     = s;
        {o.en0, o.en1, o.en2, o.en3} = en;
        o.done    = d;
        o.timeout = t;
        o.iters   = ITER_W'(it);
        return o;
    endfunction

    // Expected vectors from the LOAD cycle through FIN for a run that
    // converges in CHECK number n, or times out after n iterations.
    function automatic void push_run(int n, logic tmo);
        exp_q.push_back(mk(1'b0, 1'b0, 4'b1000, 1'b0, 1'b0, 0));
        for (int i = 1; i <= n; i++) begin
            exp_q.push_back(mk(1'b0, (i == 1), 4'b0100, 1'b0, 1'b0, i - 1));
            exp_q.push_back(mk(1'b0, 1'b0, 4'b0010, 1'b0, 1'b0, i - 1));
            exp_q.push_back(mk(1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, i));
        end
        if (!tmo) exp_q.push_back(mk(1'b0, 1'b0, 4'b0001, 1'b0, 1'b0, n));
        exp_q.push_back(mk(1'b0, 1'b0, 4'b0000, 1'b1, tmo, n));
    endfunction

    function automatic void push_idle(int n, logic tmo);
        exp_q.push_back(mk(1'b1, 1'b0, 4'b0000, 1'b0, tmo, n));
    endfunction

    task automatic test_reset();
        obs_t act, exp;
        #1 rst = 1'b1;
        #1;
        act = sample(); exp = mk(1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 0);
        total++;
        if (act !== exp) $display("FAIL reset_init: got %b expected %b", act, exp);
        else passed++;
        @(negedge clk); rst = 1'b0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        act = sample(); exp = mk(1'b0, 1'b0, 4'b1000, 1'b0, 1'b0, 0);
        total++;
        if (act !== exp) $display("FAIL reset_load: got %b expected %b", act, exp);
        else passed++;
        @(negedge clk);
        act = sample(); exp = mk(1'b0, 1'b1, 4'b0100, 1'b0, 1'b0, 0);
        total++;
        if (act !== exp) $display("FAIL reset_calc: got %b expected %b", act, exp);
        else passed++;
        // Assert reset mid-CALC while the clock is low: must act at once.
        #2 rst = 1'b1;
        #1;
        act = sample(); exp = mk(1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 0);
        total++;
        if (act !== exp) $display("FAIL reset_async: got %b expected %b", act, exp);
        else passed++;
        @(negedge clk);
        @(negedge clk); rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            act = sample();
            total++;
            if (act !== exp) $display("FAIL reset_after%0d: got %b expected %b", i, act, exp);
            else passed++;
            complete = 1'($urandom_range(0, 1));
        end
        complete = 1'b0;
    endtask

    task automatic test_converge(input int n);
        obs_t act, exp;
        int   len, first_done, n2, n3;
        exp_q.delete();
        push_run(n, 1'b0);
        push_idle(n, 1'b0);
        len = exp_q.size(); first_done = -1; n2 = 0; n3 = 0;
        start = 1'b1;
        for (int idx = 0; idx < len; idx++) begin
            @(negedge clk);
            act = sample(); exp = exp_q.pop_front();
            total++;
            if (act !== exp) $display("FAIL conv%0d_cycle%0d: got %b expected %b", n, idx, act, exp);
            else passed++;
            if (act.done === 1'b1 && first_done < 0) first_done = idx;
            if (act.en2 === 1'b1) n2++;
            if (act.en3 === 1'b1) n3++;
            start = 1'b0;
            if (idx == 3 * n) complete = 1'b1;
            else if (idx > 0 && idx % 3 == 0) complete = 1'b0;
            else complete = 1'($urandom_range(0, 1));
        end
        complete = 1'b0;
        total++;
        if (first_done !== 3 * n + 2) $display("FAIL conv%0d_latency: got %0d expected %0d", n, first_done, 3 * n + 2);
        else passed++;
        total++;
        if (n2 !== n || n3 !== 1) $display("FAIL conv%0d_enables: got en2=%0d en3=%0d expected en2=%0d en3=1", n, n2, n3, n);
        else passed++;
    endtask

    task automatic test_timeout();
        obs_t act, exp;
        int   len, first_done, n2, n3;
        exp_q.delete();
        push_run(MAX_ITER, 1'b1);
        push_idle(MAX_ITER, 1'b1);
        len = exp_q.size(); first_done = -1; n2 = 0; n3 = 0;
        start = 1'b1;
        for (int idx = 0; idx < len; idx++) begin
            @(negedge clk);
            act = sample(); exp = exp_q.pop_front();
            total++;
            if (act !== exp) $display("FAIL timeout_cycle%0d: got %b expected %b", idx, act, exp);
            else passed++;
            if (act.done === 1'b1 && first_done < 0) first_done = idx;
            if (act.en2 === 1'b1) n2++;
            if (act.en3 === 1'b1) n3++;
            start = 1'b0;
            if (idx > 0 && idx % 3 == 0) complete = 1'b0;
            else complete = 1'($urandom_range(0, 1));
        end
        complete = 1'b0;
        total++;
        if (first_done !== 3 * MAX_ITER + 1) $display("FAIL timeout_latency: got %0d expected %0d", first_done, 3 * MAX_ITER + 1);
        else passed++;
        total++;
        if (n2 !== MAX_ITER || n3 !== 0) $display("FAIL timeout_enables: got en2=%0d en3=%0d expected en2=%0d en3=0", n2, n3, MAX_ITER);
        else passed++;
    endtask

    // Run of 2 iterations with start pulsed while busy, then start held
    // through FIN so a 1-iteration run follows immediately. The first LOAD
    // also shows the timeout left by the previous run being cleared.
    task automatic test_back_to_back();
        obs_t act, exp;
        int   len, first_done, load2;
        exp_q.delete();
        push_run(2, 1'b0);
        push_idle(2, 1'b0);
        push_run(1, 1'b0);
        push_idle(1, 1'b0);
        len = exp_q.size(); first_done = -1; load2 = -1;
        start = 1'b1;
        for (int idx = 0; idx < len; idx++) begin
            @(negedge clk);
            act = sample(); exp = exp_q.pop_front();
            total++;
            if (act !== exp) $display("FAIL b2b_cycle%0d: got %b expected %b", idx, act, exp);
            else passed++;
            if (act.done === 1'b1 && first_done < 0) first_done = idx;
            if (act.en0 === 1'b1 && idx > 0 && load2 < 0) load2 = idx;
            start = (idx == 2 || idx == 3 || idx == 5 || idx == 6 || idx == 8 || idx == 9);
            if (idx == 6 || idx == 13) complete = 1'b1;
            else if (idx == 3) complete = 1'b0;
            else complete = 1'($urandom_range(0, 1));
        end
        start = 1'b0; complete = 1'b0;
        total++;
        if (first_done !== 8) $display("FAIL b2b_done: got %0d expected 8", first_done);
        else passed++;
        total++;
        if (load2 - first_done !== 2) $display("FAIL b2b_restart_gap: got %0d expected 2", load2 - first_done);
        else passed++;
    endtask

    task automatic test_onehot();
        total++;
        if (onehot_viol !== 0) $display("FAIL onehot: got %0d violations expected 0", onehot_viol);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_converge(1);
        test_converge(3);
        test_timeout();
        test_back_to_back();
        test_onehot();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
